// File: rtl/aes_pkg.sv
// Shared AES-128 constants and helpers: S-box table, sub_word, xtime, round-counter type.
package aes_pkg;

    typedef logic [3:0] round_t;

    localparam round_t     AES_NR    = 4'd10;
    localparam logic [7:0] RCON_INIT = 8'h01;

    // Byte b of the S-box sits at bits [8*(255-b)+7 -: 8], i.e. entry 0 is the MSB byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (8'h1b & {8{r[7]}});
    endfunction

    function automatic logic [7:0] gf_mult2(input logic [7:0] r);
        return xtime(r);
    endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// One AES-128 key-schedule step: current round key + rcon -> next round key (combinational).
module aes_key_expand_step
    import aes_pkg::*;
(
    input  logic [127:0] cur_key,
    input  logic [7:0]   rcon,
    output logic [127:0] next_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t, n0, n1, n2, n3;

    assign w0 = cur_key[31:0];
    assign w1 = cur_key[63:32];
    assign w2 = cur_key[95:64];
    assign w3 = cur_key[127:96];

    assign t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = {n3, n2, n1, n0};

endmodule

// File: rtl/aes_round_key_stage.sv
// AddRoundKey stage with an on-the-fly AES-128 key schedule and a single registered output slot.
// Define AES_RKS_ROUND_OUT_EN to expose the per-beat round index on out_round.
module aes_round_key_stage
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         key_load,
    input  logic [127:0] key_in,
    output logic         key_ready,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
`ifdef AES_RKS_ROUND_OUT_EN
    output logic [3:0]   out_round,
`endif
    output logic         out_final
);

    typedef enum logic {NOKEY, KEYED} ctl_state_t;

    ctl_state_t   state, state_n;
    logic [127:0] base_key, cur_key, next_key;
    round_t       round;
    logic [7:0]   rcon;
    logic         accept, last;

    always_ff @(posedge clk) begin
        if (rst) state <= NOKEY;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (key_load) state_n = KEYED;
    end

    assign key_ready = (state == KEYED);
    assign in_ready  = key_ready && !key_load && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign last      = (round == AES_NR);

    aes_key_expand_step u_step (
        .cur_key  (cur_key),
        .rcon     (rcon),
        .next_key (next_key)
    );

    // Key schedule: accept and key_load are mutually exclusive since in_ready masks load cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_key <= '0;
            cur_key  <= '0;
            round    <= '0;
            rcon     <= RCON_INIT;
        end else if (key_load) begin
            base_key <= key_in;
            cur_key  <= key_in;
            round    <= '0;
            rcon     <= RCON_INIT;
        end else if (accept) begin
            if (last) begin
                cur_key <= base_key;
                round   <= '0;
                rcon    <= RCON_INIT;
            end else begin
                cur_key <= next_key;
                round   <= round + 4'd1;
                rcon    <= xtime(rcon);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_state <= '0;
            out_final <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_state <= in_state ^ cur_key;
            out_final <= last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef AES_RKS_ROUND_OUT_EN
    always_ff @(posedge clk) begin
        if (rst)         out_round <= '0;
        else if (accept) out_round <= round;
    end
`endif

endmodule

// File: tb/tb_aes_round_key_stage.sv
// Bench for aes_round_key_stage: randomized beats checked against an FIPS-197-style key expansion model.
module tb_aes_round_key_stage;

    logic         clk = 1'b0;
    logic         rst, key_load, in_valid, out_ready;
    logic [127:0] key_in, in_state;
    logic         key_ready, in_ready, out_valid, out_final;
    logic [127:0] out_state;
`ifdef AES_RKS_ROUND_OUT_EN
    logic [3:0]   out_round;
`endif

    always #5 clk = ~clk;

    aes_round_key_stage dut (
        .clk       (clk),
        .rst       (rst),
        .key_load  (key_load),
        .key_in    (key_in),
        .key_ready (key_ready),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
`ifdef AES_RKS_ROUND_OUT_EN
        .out_round (out_round),
`endif
        .out_final (out_final)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0]   sb [256];
    logic [127:0] rk [11];
    logic         m_keyed, m_valid, m_final, m_in_ready;
    logic [127:0] m_state;
    int           m_oround, m_rnd;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from first principles: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_keyed = 0; m_valid = 0; m_final = 0; m_state = '0; m_oround = 0; m_rnd = 0;
        end else begin
            if (m_in_ready && in_valid) begin
                m_valid  = 1;
                m_state  = in_state ^ rk[m_rnd];
                m_final  = (m_rnd == 10);
                m_oround = m_rnd;
                m_rnd    = (m_rnd == 10) ? 0 : m_rnd + 1;
            end else if (out_ready) begin
                m_valid = 0;
            end
            if (key_load) begin
                m_keyed = 1;
                m_rnd   = 0;
                expand(key_in);
            end
        end
    endtask

    task automatic tick();
        #1;
        m_in_ready = m_keyed && !key_load && (!m_valid || out_ready);
        chk("key_ready", 128'(key_ready), 128'(m_keyed));
        chk("in_ready", 128'(in_ready), 128'(m_in_ready));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("out_valid", 128'(out_valid), 128'(m_valid));
        chk("out_state", out_state, m_state);
        chk("out_final", 128'(out_final), 128'(m_final));
`ifdef AES_RKS_ROUND_OUT_EN
        chk("out_round", 128'(out_round), 128'(m_oround));
`endif
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [127:0] KEY0 = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
    localparam logic [127:0] RK1  = 128'h2a6c7605_23a33939_88542cb1_a0fafe17;
    localparam logic [127:0] RK10 = 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8;

    logic [127:0] held, k2, st;

    initial begin
        build_sbox();
        expand('0);
        m_keyed = 0; m_valid = 0; m_final = 0; m_state = '0; m_oround = 0; m_rnd = 0;
        rst = 1; key_load = 0; key_in = '0; in_valid = 0; out_ready = 0; in_state = '0;
        @(negedge clk);
        tick(); tick();
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_state", out_state, 128'd0);
        rst = 0;

        // Beats before any key must be ignored
        in_valid = 1; in_state = rnd128(); out_ready = 1;
        tick(); tick();
        chk("nokey_ignored", 128'(out_valid), 128'd0);

        // Known-answer block, back-to-back
        key_load = 1; key_in = KEY0; in_valid = 0;
        tick();
        key_load = 0; in_valid = 1; in_state = '0;
        for (int b = 0; b < 12; b++) begin
            tick();
            if (b == 0 || b == 11) chk("kat_rk0", out_state, KEY0);
            if (b == 1)  chk("kat_rk1", out_state, RK1);
            if (b == 10) begin
                chk("kat_rk10", out_state, RK10);
                chk("kat_final", 128'(out_final), 128'd1);
            end
        end

        // Backpressure: slot full, downstream stalled
        out_ready = 0; in_state = rnd128();
        tick();
        held = out_state;
        for (int i = 0; i < 5; i++) begin
            in_state = rnd128();
            tick();
            chk("bp_in_ready", 128'(in_ready), 128'd0);
            chk("bp_hold", out_state, held);
        end
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            in_state = rnd128();
            tick();
        end

        // key_load mid-block at beat 4
        key_load = 1; key_in = rnd128(); in_valid = 0;
        tick();
        key_load = 0; in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            in_state = rnd128();
            tick();
        end
        k2 = rnd128();
        key_load = 1; key_in = k2; in_state = rnd128();
        #1 chk("load_in_ready", 128'(in_ready), 128'd0);
        tick();
        key_load = 0; st = rnd128(); in_state = st;
        tick();
        chk("reload_beat", out_state, st ^ k2);

        // Reset mid-block
        for (int i = 0; i < 3; i++) begin
            in_state = rnd128();
            tick();
        end
        rst = 1;
        tick();
        rst = 0;
        chk("midrst_valid", 128'(out_valid), 128'd0);
        chk("midrst_key_ready", 128'(key_ready), 128'd0);
        for (int i = 0; i < 3; i++) begin
            in_state = rnd128();
            tick();
        end

        // Randomized traffic with occasional key reloads
        key_load = 1; key_in = rnd128();
        tick();
        key_load = 0;
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_state  = rnd128();
            key_load  = ($urandom_range(0, 39) == 0);
            if (key_load) key_in = rnd128();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
